// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle for rr_arbiter16.
// The master side (requesters) drives req/done; the slave side (arbiter)
// drives the registered grant outputs.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        en;
  logic        timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  en,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output en,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way rotating-priority arbiter with a two-state FSM
// (IDLE/GRANT). A grant is held until the holder strobes done; every release
// is followed by at least one idle cycle. All outputs come from registers.
// Optional feature: define ARB_TIMEOUT_EN to add an 8-bit hold counter that
// forcibly releases a grant after TIMEOUT cycles and pulses timeout.
module rr_arbiter16 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  rr_arbiter16_if.slave bus
);

  // Elaboration-time guard on the hold limit.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arbiter16: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] gnt_q, gnt_d;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // Request vector rotated so that bit 0 is the requester at ptr_q.
  logic [15:0] rot_req;
  for (genvar gi = 0; gi < 16; gi++) begin : g_rot
    assign rot_req[gi] = bus.req[ptr_q + 4'(gi)];
  end

  logic [3:0] win_off;
  logic [3:0] win_idx;

  // Lowest set bit of the rotated vector is the winner's offset from ptr_q.
  always_comb begin
    win_off = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (rot_req[k]) win_off = 4'(k);
    end
  end

  assign win_idx = ptr_q + win_off;

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // done is meaningless while idle and is ignored here.
        if (|bus.req) begin
          state_d = GRANT;
          idx_d   = win_idx;
          gnt_d   = 16'd1 << win_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
        // Requests are not looked at while granted; only done (or the
        // hold limit) ends the grant. gnt_idx keeps its last value.
        if (bus.done) begin
          state_d = IDLE;
          gnt_d   = 16'd0;
          ptr_d   = idx_q + 4'd1;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
          state_d   = IDLE;
          gnt_d     = 16'd0;
          ptr_d     = idx_q + 4'd1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 16'd0;
      end
    endcase
  end

  // State and output registers; reset drops any grant without a timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      idx_q   <= 4'd0;
      gnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-cycle forced-release flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.en      = (state_q == GRANT);

endmodule
